fifo_uart_tx: RTL and testbench

//   Downstream consumer for the 8-bit single-clock asynchronous_fifo. Pops one byte

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pops bytes from an 8-bit single-clock FIFO and serialises each one as a
//   UART frame on tx: start bit, 8 data bits LSB first, optional even parity,
//   then one or two stop bits.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_EN     1 inserts an even-parity bit after the data bits
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   fifo_empty    FIFO empty flag (sampled only while idle)
//   fifo_data     FIFO read data, valid the cycle after fifo_read_en
//   fifo_read_en  one-cycle pop request
//   tx            registered serial output, idles high
//   busy          high from the pop cycle through the last stop-bit cycle
//   frame_done    one-cycle pulse on the final stop-bit cycle
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          parity, parity_n;
  logic          tx_d;
  logic          cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      parity  <= parity_n;
      tx      <= tx_d;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    parity_n     = parity;
    fifo_read_en = 1'b0;
    frame_done   = 1'b0;

    case (state)
      IDLE: begin
        // Gated by rst so no pop request escapes while reset is held.
        if (!fifo_empty && rst) begin
          fifo_read_en = 1'b1;
          state_n      = WAIT;
        end
      end

      WAIT: begin
        shreg_n   = fifo_data;
        parity_n  = ^fifo_data;
        cnt_n     = '0;
        bit_cnt_n = '0;
        state_n   = START;
      end

      START: begin
        if (cnt_last) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      PARITY: begin
        if (cnt_last) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        // bit_cnt counts stop bits so the baud counter stays CLKS_PER_BIT wide.
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            frame_done = 1'b1;
            bit_cnt_n  = '0;
            state_n    = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // tx is the registered line level of the state entered next cycle, so the
  // output flop flips exactly at the state/bit boundary.
  always_comb begin
    tx_d = 1'b1;
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_n[0];
      PARITY:  tx_d = parity_n;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy = (state != IDLE) || fifo_read_en;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Three transmitters share clk/rst:
//     0: CLKS_PER_BIT=4, no parity, 1 stop bit
//     1: CLKS_PER_BIT=4, even parity, 1 stop bit
//     2: CLKS_PER_BIT=2, no parity, 2 stop bits
//   Stimulus pushes a byte into a FIFO model and its expected frame
//   ({parity, byte}) into a scoreboard queue; per-DUT monitors capture each
//   frame from tx and compare it against the popped expectation.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] fifo_empty = '1;
  logic [7:0] fdata [3];
  logic [2:0] rd_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] fd_v;

  logic [7:0] src_q [3][$];
  logic [8:0] exp_q [3][$];

  int checks = 0;
  int errors = 0;
  int rd_cnt [3] = '{0, 0, 0};
  int fd_cnt [3] = '{0, 0, 0};
  int last_gap [3] = '{-1, -1, -1};

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fdata[0]),
    .fifo_read_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fdata[1]),
    .fifo_read_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[2]), .fifo_data(fdata[2]),
    .fifo_read_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

  function automatic int cpb_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int sb_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return cpb_of(k) * (10 + par_of(k) + sb_of(k) - 1);
  endfunction

  function automatic logic exp_level(input logic [8:0] e, input int k, input int idx);
    int b;
    b = idx / cpb_of(k);
    if (b == 0) return 1'b0;
    if (b <= 8) return e[b-1];
    if (par_of(k) != 0 && b == 9) return e[8];
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO model: data appears the cycle after the pop request.
  always @(posedge clk) begin
    logic [2:0] r;
    r = rd_v;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r[k] && src_q[k].size() > 0) fdata[k] = src_q[k].pop_front();
      fifo_empty[k] = (src_q[k].size() == 0);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_v[k]) rd_cnt[k]++;
      if (fd_v[k]) fd_cnt[k]++;
    end
  end

  task automatic monitor(input int k);
    int gap;
    int mism;
    int len;
    bit aborted;
    bit done;
    bit bad_busy;
    logic samp[$];
    logic [8:0] e;
    gap = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        gap = -1;
        continue;
      end
      if (tx_v[k] !== 1'b0) begin
        if (gap >= 0) gap++;
        continue;
      end
      last_gap[k] = gap;
      gap = -1;
      samp = {};
      aborted = 1'b0;
      done = 1'b0;
      bad_busy = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (c > 0) @(negedge clk);
        if (!rst) begin
          aborted = 1'b1;
          break;
        end
        samp.push_back(tx_v[k]);
        if (busy_v[k] !== 1'b1) bad_busy = 1'b1;
        if (fd_v[k]) begin
          done = 1'b1;
          break;
        end
      end
      if (aborted) continue;
      check($sformatf("frame%0d_done_seen", k), int'(done), 1);
      gap = 0;
      if (exp_q[k].size() == 0) begin
        check($sformatf("frame%0d_unexpected", k), 1, 0);
        continue;
      end
      e = exp_q[k].pop_front();
      len = frame_len(k);
      mism = 0;
      for (int i = 0; i < samp.size(); i++)
        if (i < len && samp[i] !== exp_level(e, k, i)) mism++;
      check($sformatf("frame%0d_len_byte%02h", k, e[7:0]), samp.size(), len);
      check($sformatf("frame%0d_levels_byte%02h", k, e[7:0]), mism, 0);
      check($sformatf("frame%0d_busy", k), int'(bad_busy), 0);
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic push(input int k, input logic [7:0] d, input logic p);
    @(negedge clk);
    src_q[k].push_back(d);
    exp_q[k].push_back({p, d});
  endtask

  task automatic wait_done(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q[k].size() == 0 && src_q[k].size() == 0 &&
          fifo_empty[k] && !busy_v[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("dut%0d_drained", k), int'(ok), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd0;
    int rd0;
    bit ok;

    // Reset held with FIFOs empty, then released.
    repeat (4) @(negedge clk);
    check("reset_tx", int'(tx_v), 7);
    check("reset_busy", int'(busy_v), 0);
    check("reset_read_en", int'(rd_v), 0);
    check("reset_frame_done", int'(fd_v), 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_tx", int'(tx_v), 7);
    check("post_reset_busy", int'(busy_v), 0);
    check("post_reset_reads", rd_cnt[0] + rd_cnt[1] + rd_cnt[2], 0);

    // Single byte 0x0A.
    push(0, 8'h0A, 1'b0);
    wait_done(0);
    check("single_reads", rd_cnt[0], 1);
    check("single_frame_done", fd_cnt[0], 1);

    // Back-to-back 0xA5, 0x3C.
    push(0, 8'hA5, 1'b0);
    push(0, 8'h3C, 1'b0);
    wait_done(0);
    check("b2b_reads", rd_cnt[0], 3);
    check("b2b_frame_done", fd_cnt[0], 3);
    check("b2b_gap", last_gap[0], 2);

    // Even parity: 0x07 -> 1, 0x03 -> 0.
    push(1, 8'h07, 1'b1);
    push(1, 8'h03, 1'b0);
    wait_done(1);
    check("parity_reads", rd_cnt[1], 2);
    check("parity_frame_done", fd_cnt[1], 2);

    // Two stop bits at 2 clocks per bit.
    push(2, 8'h5B, 1'b1);
    wait_done(2);
    check("stop2_reads", rd_cnt[2], 1);
    check("stop2_frame_done", fd_cnt[2], 1);

    // Reset mid-DATA for 0xFF: the byte is dropped, nothing re-read.
    @(negedge clk);
    src_q[0].push_back(8'hFF);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_start_seen", int'(ok), 1);
    repeat (8) @(negedge clk);
    check("abort_busy_before", int'(busy_v[0]), 1);
    fd0 = fd_cnt[0];
    rd0 = rd_cnt[0];
    rst = 1'b0;
    #1;
    check("abort_tx_immediate", int'(tx_v[0]), 1);
    check("abort_busy_immediate", int'(busy_v[0]), 0);
    check("abort_read_en", int'(rd_v[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_frame_done", fd_cnt[0], fd0);
    check("abort_no_reread", rd_cnt[0], rd0);
    check("abort_tx_idle", int'(tx_v), 7);
    check("abort_busy_idle", int'(busy_v), 0);
    check("scoreboard_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
